// File: rtl/vga_config_master_if.sv
// Config bus between the resolution master and the VGA configuration receiver.
// The master issues a one-cycle write strobe with address/data; the receiver
// answers with a one-cycle acknowledge pulse on C_rdy.
interface vga_config_master_if #(
   parameter int CONFIG_WIDTH = 8
);
   logic                    C_valid;
   logic [CONFIG_WIDTH-1:0] C_addr;
   logic [CONFIG_WIDTH-1:0] C_data;
   logic                    C_rdy;

   modport master (
      output C_valid,
      output C_addr,
      output C_data,
      input  C_rdy
   );

   modport slave (
      input  C_valid,
      input  C_addr,
      input  C_data,
      output C_rdy
   );
endinterface

// File: rtl/vga_config_master.sv
// VGA resolution config master.
// A legal request is written to the resolution register on the config bus and
// waits for an acknowledge. If no acknowledge arrives within ACK_TIMEOUT cycles,
// the write is retried up to MAX_RETRY times before an error is reported.
// All outputs come straight from flops.
module vga_config_master #(
   parameter int CONFIG_WIDTH    = 8,
   parameter int ADDR_VGA_CONFIG = 0,
   parameter int ACK_TIMEOUT     = 15,   // 1..255
   parameter int MAX_RETRY       = 3     // 0..7
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic [1:0]                 Res_sel,
   input  logic                       Res_req,
   vga_config_master_if.master        cfg,
   output logic                       Busy,
   output logic                       Done,
   output logic                       Error,
   output logic [1:0]                 Cur_res
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2,
      GAP      = 2'd3
   } state_t;

   // The last timer value of a wait window; hitting it with no acknowledge
   // means the window is over. This makes WAIT_ACK last exactly ACK_TIMEOUT cycles.
   localparam logic [7:0]              TIMER_LAST  = 8'(ACK_TIMEOUT - 1);
   localparam logic [2:0]              RETRY_LIMIT = 3'(MAX_RETRY);
   localparam logic [CONFIG_WIDTH-1:0] ADDR_C      = CONFIG_WIDTH'(ADDR_VGA_CONFIG);

   state_t                  state_reg;
   logic [1:0]              pend_reg;
   logic [7:0]              timer_reg;
   logic [2:0]              retry_reg;
   logic                    c_valid_reg;
   logic [CONFIG_WIDTH-1:0] c_addr_reg;
   logic [CONFIG_WIDTH-1:0] c_data_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    error_reg;
   logic [1:0]              cur_res_reg;

   // Request/write/acknowledge FSM. Each output is loaded on the same edge as
   // the state change that defines it, so each output lines up with its state.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg   <= IDLE;
         pend_reg    <= 2'b00;
         timer_reg   <= 8'd0;
         retry_reg   <= 3'd0;
         c_valid_reg <= 1'b0;
         c_addr_reg  <= '0;
         c_data_reg  <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
         cur_res_reg <= 2'b00;
      end else begin
         // The strobes are single-cycle pulses unless they are re-armed below.
         c_valid_reg <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (Res_req) begin
                  if (Res_sel == 2'b11) begin
                     // Illegal resolution: reject it at once and do no bus traffic.
                     error_reg <= 1'b1;
                  end else begin
                     pend_reg    <= Res_sel;
                     retry_reg   <= 3'd0;
                     state_reg   <= SEND;
                     busy_reg    <= 1'b1;
                     c_valid_reg <= 1'b1;
                     c_addr_reg  <= ADDR_C;
                     c_data_reg  <= CONFIG_WIDTH'(Res_sel);
                  end
               end
            end

            SEND: begin
               // The strobe was raised on entry, so this is its only cycle.
               state_reg <= WAIT_ACK;
               timer_reg <= 8'd0;
            end

            WAIT_ACK: begin
               if (cfg.C_rdy) begin
                  // The acknowledge is checked first, so it wins over a
                  // timeout in the same cycle.
                  cur_res_reg <= pend_reg;
                  done_reg    <= 1'b1;
                  state_reg   <= GAP;
               end else if (timer_reg == TIMER_LAST) begin
                  if (retry_reg < RETRY_LIMIT) begin
                     retry_reg   <= retry_reg + 3'd1;
                     state_reg   <= SEND;
                     c_valid_reg <= 1'b1;
                     c_addr_reg  <= ADDR_C;
                     c_data_reg  <= CONFIG_WIDTH'(pend_reg);
                  end else begin
                     // No retries left: give up and leave Cur_res as it was.
                     error_reg <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  timer_reg <= timer_reg + 8'd1;
               end
            end

            GAP: begin
               // This one idle cycle lets Done be seen before a new request can start.
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg.C_valid = c_valid_reg;
   assign cfg.C_addr  = c_addr_reg;
   assign cfg.C_data  = c_data_reg;
   assign Busy        = busy_reg;
   assign Done        = done_reg;
   assign Error       = error_reg;
   assign Cur_res     = cur_res_reg;

endmodule

// File: tb/tb_vga_config_master.sv
// Testbench for vga_config_master. It runs directed scenarios against a
// schedule-based reference. For each transaction the reference computes the
// expected bus activity from the accept edge: attempt k is sent at
// start + k*(ACK_TIMEOUT+1), and the acknowledge window of each attempt is
// known. Literal checks in the stimulus pin the reference to hand-computed values.
module tb_vga_config_master;

   localparam int T = 15;   // ACK_TIMEOUT
   localparam int M = 3;    // MAX_RETRY

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [1:0] Res_sel = 2'b00;
   logic       Res_req = 1'b0;
   logic       Busy, Done, Error;
   logic [1:0] Cur_res;

   vga_config_master_if #(.CONFIG_WIDTH(8)) cfg ();

   vga_config_master #(
      .CONFIG_WIDTH   (8),
      .ADDR_VGA_CONFIG(0),
      .ACK_TIMEOUT    (T),
      .MAX_RETRY      (M)
   ) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Res_sel(Res_sel),
      .Res_req(Res_req),
      .cfg    (cfg),
      .Busy   (Busy),
      .Done   (Done),
      .Error  (Error),
      .Cur_res(Cur_res)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // Reference state: one in-flight transaction, described by its start edge.
   int         edge_n  = 0;
   int         m_start = 0;
   int         m_pend  = 0;
   bit         m_active = 1'b0;
   bit         m_gap    = 1'b0;
   logic       e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   logic [7:0] e_addr = 8'h00, e_data = 8'h00;
   logic [1:0] e_cur = 2'b00;

   // Reference update on every active edge. It uses the inputs the DUT sees there.
   always @(posedge Clk or negedge Rst) begin : model
      int d, k, r;
      if (!Rst) begin
         m_active = 1'b0; m_gap = 1'b0;
         e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
         e_addr = 8'h00; e_data = 8'h00; e_cur = 2'b00;
      end else begin
         edge_n++;
         e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
         if (m_active) begin
            d = edge_n - m_start;
            k = d / (T + 1);
            r = d % (T + 1);
            // Acknowledge windows run from offset 2 to offset T+1 after each send.
            if (cfg.C_rdy && (r >= 2 || (r == 0 && d > 0))) begin
               e_done = 1'b1; e_cur = 2'(m_pend);
               m_active = 1'b0; m_gap = 1'b1;
            end else if (r == 0 && d > 0) begin
               if (k <= M) e_valid = 1'b1;
               else begin e_err = 1'b1; m_active = 1'b0; end
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (Res_req) begin
            if (Res_sel == 2'b11) e_err = 1'b1;
            else begin
               m_active = 1'b1; m_start = edge_n; m_pend = int'(Res_sel);
               e_valid = 1'b1; e_addr = 8'h00; e_data = 8'(Res_sel);
            end
         end
         e_busy = m_active || m_gap;
      end
   end

   // Compare process: check the DUT against the reference mid-cycle, and
   // gather pulse statistics for the scenario checks.
   int cyc = 0;
   int err_cnt = 0;
   int done_cnt = 0;
   int valid_times[$];

   always @(negedge Clk) begin
      cyc++;
      chk("cmp_c_valid", 32'(cfg.C_valid), 32'(e_valid));
      chk("cmp_c_addr",  32'(cfg.C_addr),  32'(e_addr));
      chk("cmp_c_data",  32'(cfg.C_data),  32'(e_data));
      chk("cmp_busy",    32'(Busy),        32'(e_busy));
      chk("cmp_done",    32'(Done),        32'(e_done));
      chk("cmp_error",   32'(Error),       32'(e_err));
      chk("cmp_cur_res", 32'(Cur_res),     32'(e_cur));
      if (cfg.C_valid === 1'b1) valid_times.push_back(cyc);
      if (Error === 1'b1) err_cnt++;
      if (Done === 1'b1) done_cnt++;
   end

   task automatic tick(int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
      end
   endtask

   task automatic request(logic [1:0] sel);
      Res_sel = sel;
      Res_req = 1'b1;
      tick(1);
      Res_req = 1'b0;
   endtask

   initial begin
      int e0, d0;
      cfg.C_rdy = 1'b0;

      // Reset state
      tick(3);
      chk("rst_c_valid", 32'(cfg.C_valid), 0);
      chk("rst_c_addr",  32'(cfg.C_addr),  0);
      chk("rst_c_data",  32'(cfg.C_data),  0);
      chk("rst_busy",    32'(Busy),        0);
      chk("rst_cur_res", 32'(Cur_res),     0);
      Rst = 1'b1;
      tick(2);

      // No acknowledge: expect 4 sends 16 cycles apart, then an error.
      valid_times.delete();
      e0 = err_cnt; d0 = done_cnt;
      request(2'b01);
      for (int i = 0; i < 150 && Busy === 1'b1; i++) tick(1);
      chk("timeout_idle",      32'(Busy), 0);
      chk("timeout_err_now",   32'(Error), 1);
      chk("timeout_sends",     32'(valid_times.size()), 4);
      for (int i = 1; i < valid_times.size(); i++)
         chk("timeout_spacing", 32'(valid_times[i] - valid_times[i-1]), 16);
      chk("timeout_err_cnt",   32'(err_cnt - e0), 1);
      chk("timeout_no_done",   32'(done_cnt - d0), 0);
      chk("timeout_cur_res",   32'(Cur_res), 0);
      tick(1);
      chk("timeout_err_pulse", 32'(Error), 0);
      tick(2);

      // Basic write with the acknowledge two cycles after the send
      valid_times.delete();
      request(2'b01);
      chk("basic_c_valid", 32'(cfg.C_valid), 1);
      chk("basic_c_addr",  32'(cfg.C_addr),  32'h00);
      chk("basic_c_data",  32'(cfg.C_data),  32'h01);
      chk("basic_busy",    32'(Busy), 1);
      tick(2);
      cfg.C_rdy = 1'b1;
      tick(1);
      cfg.C_rdy = 1'b0;
      chk("basic_done",    32'(Done), 1);
      chk("basic_cur_res", 32'(Cur_res), 1);
      chk("basic_gap_busy",32'(Busy), 1);
      tick(1);
      chk("basic_idle",    32'(Busy), 0);
      chk("basic_done_pulse", 32'(Done), 0);
      chk("basic_sends",   32'(valid_times.size()), 1);
      tick(2);

      // Illegal resolution
      valid_times.delete();
      request(2'b11);
      chk("illegal_error", 32'(Error), 1);
      chk("illegal_busy",  32'(Busy), 0);
      chk("illegal_valid", 32'(cfg.C_valid), 0);
      tick(1);
      chk("illegal_err_pulse", 32'(Error), 0);
      chk("illegal_sends", 32'(valid_times.size()), 0);
      tick(2);

      // A request made while busy is ignored.
      valid_times.delete();
      request(2'b00);
      tick(2);
      Res_sel = 2'b10;
      Res_req = 1'b1;
      tick(3);
      Res_req = 1'b0;
      cfg.C_rdy = 1'b1;
      tick(1);
      cfg.C_rdy = 1'b0;
      chk("busyreq_done",    32'(Done), 1);
      chk("busyreq_cur_res", 32'(Cur_res), 0);
      chk("busyreq_c_data",  32'(cfg.C_data), 0);
      tick(4);
      chk("busyreq_idle",    32'(Busy), 0);
      chk("busyreq_sends",   32'(valid_times.size()), 1);
      chk("busyreq_cur_res2",32'(Cur_res), 0);

      // Acknowledge in the same cycle as the timeout: the acknowledge wins.
      valid_times.delete();
      e0 = err_cnt;
      request(2'b10);
      tick(15);
      cfg.C_rdy = 1'b1;
      tick(1);
      cfg.C_rdy = 1'b0;
      chk("edge_ack_done",    32'(Done), 1);
      chk("edge_ack_valid",   32'(cfg.C_valid), 0);
      chk("edge_ack_error",   32'(Error), 0);
      chk("edge_ack_cur_res", 32'(Cur_res), 2);
      tick(20);
      chk("edge_ack_sends",   32'(valid_times.size()), 1);
      chk("edge_ack_no_err",  32'(err_cnt - e0), 0);
      chk("edge_ack_idle",    32'(Busy), 0);

      // Reset in the 5th WAIT_ACK cycle, then run a new transaction.
      request(2'b01);
      tick(5);
      #2 Rst = 1'b0;
      #1;
      chk("arst_c_valid", 32'(cfg.C_valid), 0);
      chk("arst_c_addr",  32'(cfg.C_addr),  0);
      chk("arst_c_data",  32'(cfg.C_data),  0);
      chk("arst_busy",    32'(Busy), 0);
      chk("arst_done",    32'(Done), 0);
      chk("arst_error",   32'(Error), 0);
      chk("arst_cur_res", 32'(Cur_res), 0);
      tick(2);
      Rst = 1'b1;
      valid_times.delete();
      tick(40);
      chk("arst_no_sends", 32'(valid_times.size()), 0);
      request(2'b10);
      chk("arst_new_valid", 32'(cfg.C_valid), 1);
      chk("arst_new_data",  32'(cfg.C_data), 2);
      tick(3);
      cfg.C_rdy = 1'b1;
      tick(1);
      cfg.C_rdy = 1'b0;
      chk("arst_new_done",  32'(Done), 1);
      chk("arst_new_cur",   32'(Cur_res), 2);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_config_master.md
VGA_CONFIG_MASTER -- requirements
Module: vga_config_master

Interface
REQ-001 The block SHALL have parameter CONFIG_WIDTH, default 8, the config bus address/data width.
REQ-002 The block SHALL have parameter ADDR_VGA_CONFIG, default 0, the address of the VGA resolution register.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 15, legal range 1..255, the number of WAIT_ACK cycles before a retry.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, legal range 0..7, the number of retries after the first attempt.
REQ-005 Port Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Port Rst  input  1  reset; asynchronous, active-low.
REQ-007 Port Res_sel  input  2  requested resolution: 00=640x480, 01=800x600, 10=1024x768, 11=illegal.
REQ-008 Port Res_req  input  1  request strobe; sampled only in IDLE.
REQ-009 Port C_valid  output  1  config bus write strobe.
REQ-010 Port C_addr  output  CONFIG_WIDTH  config bus address.
REQ-011 Port C_data  output  CONFIG_WIDTH  config bus data.
REQ-012 Port C_rdy  input  1  acknowledge pulse from the VGA configuration receiver.
REQ-013 Port Busy  output  1  high in every state except IDLE.
REQ-014 Port Done  output  1  one-cycle pulse on a successful acknowledge.
REQ-015 Port Error  output  1  one-cycle pulse on an illegal request or on retry exhaustion.
REQ-016 Port Cur_res  output  2  last acknowledged resolution.

Function
REQ-017 All outputs SHALL be registered; the FSM states SHALL be IDLE, SEND, WAIT_ACK and GAP.
REQ-018 In IDLE, when Res_req=1 and Res_sel!=11, the block SHALL latch Res_sel into Pend, clear the retry count and go to SEND.
REQ-019 In IDLE, when Res_req=1 and Res_sel=11, the block SHALL pulse Error for 1 cycle, stay in IDLE and leave C_valid low.
REQ-020 In SEND, the block SHALL assert C_valid for exactly 1 cycle with C_addr=ADDR_VGA_CONFIG and C_data=Pend zero-extended, then go to WAIT_ACK with timer=0.
REQ-021 Latency: C_valid SHALL be high in the cycle after the Res_req sample.
REQ-022 C_addr and C_data SHALL hold their values until the next SEND; they SHALL be 0 after reset.
REQ-023 In WAIT_ACK with C_rdy=1, the block SHALL set Cur_res<=Pend, pulse Done in the following cycle and go to GAP.
REQ-024 In WAIT_ACK with C_rdy=0, the timer SHALL increment; when timer==ACK_TIMEOUT-1 the timeout expires, so WAIT_ACK lasts ACK_TIMEOUT cycles.
REQ-025 On timeout, if retry<MAX_RETRY the block SHALL increment retry and return to SEND; otherwise it SHALL pulse Error, go to IDLE and leave Cur_res unchanged.
REQ-026 If C_rdy=1 in the same cycle as timeout expiry, the acknowledge SHALL win: Done, no retry, no Error.
REQ-027 GAP SHALL last exactly 1 cycle, then the block SHALL go to IDLE.
REQ-028 Res_req SHALL be ignored (not queued) while Busy=1.
REQ-029 C_rdy SHALL be ignored in IDLE, SEND and GAP.
REQ-030 Spacing between successive retry C_valid pulses SHALL be ACK_TIMEOUT+1 cycles.

Reset
REQ-031 On Rst=0 the block SHALL immediately set: state=IDLE; C_valid, Busy, Done, Error=0; C_addr, C_data=0; Cur_res=00; timer and retry=0.
REQ-032 Reset mid-transaction SHALL abort it without issuing further C_valid; after Rst=1 the block SHALL accept a new request.

Verification
REQ-033 Scenario: Res_sel=01 with a 1-cycle Res_req pulse -> next cycle C_valid=1, C_addr=0x00, C_data=0x01; C_rdy pulsed 2 cycles later -> Done pulse, Cur_res=01, Busy=0 after GAP.
REQ-034 Scenario: defaults, C_rdy held 0 -> 4 C_valid pulses, each 16 cycles apart; Error pulse after the 4th timeout; Cur_res stays 00.
REQ-035 Scenario: Res_sel=11 with a Res_req pulse -> Error for 1 cycle, no C_valid, Busy stays 0.
REQ-036 Scenario: Res_req pulsed while in WAIT_ACK with Res_sel=10 -> no extra C_valid; Pend and Cur_res follow the original request only.
REQ-037 Scenario: Rst=0 in the 5th WAIT_ACK cycle -> all outputs 0 asynchronously, Cur_res=00, no subsequent C_valid.
REQ-038 Scenario: C_rdy=1 exactly in the timeout-expiry cycle -> Done pulse, no retry C_valid, no Error.
